// File: rtl/whack_a_mole.sv
// whack_a_mole: single-player game core. A pseudo-random hole number (0-7)
// is shown on a 7-segment digit. The player must hit the matching button
// before the mole times out. Hits are counted on an 8-bit LED bar. After
// NUM_MOLES moles the game shows a dash with the decimal point lit, and any
// button press then starts a new game.
//
// Button handshake: there is no valid/ready pair here. Each btn bit is a raw
// asynchronous level. It is synchronised (2 FFs) and rising-edge detected
// into btn_edge, which is a one-cycle pulse per press. The FSM consumes a
// pulse only in the cycle it appears. Pulses that arrive in a state that
// ignores them are simply dropped.
module whack_a_mole #(
  parameter int         MOLE_CYCLES = 200000,
  parameter int         GAP_CYCLES  = 50000,
  parameter int         NUM_MOLES   = 20,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] led_score
);

  // The timer counts 0..N-1 for whichever phase is longer.
  localparam int TIMER_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int TW        = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TW-1:0] MOLE_LAST = TW'(MOLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [7:0]    MOLE_NUM  = 8'(NUM_MOLES);

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Segment patterns for the digits 0..7, with seg[0]=a .. seg[6]=g.
  localparam logic [6:0] SEG_LUT [8] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
  };

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_MOLE  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // FSM state. Checkers and debug can observe it by its hierarchical name.
  state_t state_q, state_d;

  logic [7:0]    btn_meta, btn_sync, btn_prev;
  logic [7:0]    btn_edge;
  logic [7:0]    lfsr_q;
  logic          lfsr_fb;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    prev_pos_q, prev_pos_d;
  logic [7:0]    mole_count_q, mole_count_d;
  logic [7:0]    mole_inc;
  logic [7:0]    score_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [2:0]    pick;
  logic          hit;
  logic          mole_end;

  // Two-FF synchroniser plus a previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  // This is a rising-edge pulse, valid for exactly one cycle per press.
  assign btn_edge = btn_sync & ~btn_prev;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1. It runs in every state, so the mole
  // sequence depends on how long the player takes.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Free-running LFSR. It is reseeded only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Candidate hole for the next mole. It never repeats the previous hole.
  always_comb begin
    pick = lfsr_q[2:0];
    if (pick == prev_pos_q) begin
      pick = pick + 3'd1;
    end
  end

  assign mole_inc = mole_count_q + 8'd1;
  assign hit      = btn_edge[prev_pos_q];
  assign mole_end = hit || (btn_edge != 8'd0) || (timer_q == MOLE_LAST);

  // State register plus every registered output and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      timer_q      <= '0;
      prev_pos_q   <= 3'd0;
      mole_count_q <= 8'd0;
      led_score    <= 8'd0;
      seg          <= SEG_BLANK;
      dp           <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prev_pos_q   <= prev_pos_d;
      mole_count_q <= mole_count_d;
      led_score    <= score_d;
      seg          <= seg_d;
      dp           <= dp_d;
    end
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    prev_pos_d   = prev_pos_q;
    mole_count_d = mole_count_q;
    score_d      = led_score;
    seg_d        = seg;
    dp_d         = dp;

    case (state_q)
      ST_GAP: begin
        // Blank display. Presses here are dropped.
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (timer_q == GAP_LAST) begin
          timer_d    = '0;
          prev_pos_d = pick;
          seg_d      = SEG_LUT[pick];
          state_d    = ST_MOLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_MOLE: begin
        // prev_pos_q holds the hole currently on display.
        seg_d = SEG_LUT[prev_pos_q];
        dp_d  = 1'b0;
        if (mole_end) begin
          // A hit wins over a wrong press or a timeout in the same cycle.
          if (hit && (led_score != 8'hFF)) begin
            score_d = led_score + 8'd1;
          end
          mole_count_d = mole_inc;
          timer_d      = '0;
          if (mole_inc == MOLE_NUM) begin
            seg_d   = SEG_DASH;
            dp_d    = 1'b1;
            state_d = ST_OVER;
          end else begin
            seg_d   = SEG_BLANK;
            state_d = ST_GAP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_OVER: begin
        // Show the final score until any press starts a new game.
        seg_d = SEG_DASH;
        dp_d  = 1'b1;
        if (btn_edge != 8'd0) begin
          score_d      = 8'd0;
          mole_count_d = 8'd0;
          timer_d      = '0;
          seg_d        = SEG_BLANK;
          dp_d         = 1'b0;
          state_d      = ST_GAP;
        end
      end

      default: begin
        state_d = ST_GAP;
        timer_d = '0;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_whack_a_mole.sv
// Self-checking bench for whack_a_mole with short timing parameters.
// The reference model tracks the game at the level of moles: the expected
// score, the previous hole, and phase lengths in cycles.
module tb_whack_a_mole;

  localparam int MOLE_CYCLES = 100;
  localparam int GAP_CYCLES  = 20;
  localparam int NUM_MOLES   = 4;

  localparam int ACT_HIT   = 0;
  localparam int ACT_HIT_X = 1;
  localparam int ACT_WRONG = 2;
  localparam int ACT_IDLE  = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] btn   = 8'd0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] led_score;

  whack_a_mole #(
    .MOLE_CYCLES (MOLE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .NUM_MOLES   (NUM_MOLES),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .seg       (seg),
    .dp        (dp),
    .led_score (led_score)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required less", $time);
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int exp_score;
  int prev_digit;
  int since_end;
  int plan [NUM_MOLES];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Maps a segment code back to its digit. Returns -1 if the code is not a digit.
  function automatic int seg2digit(input logic [6:0] s);
    case (s)
      7'h3F: return 0;
      7'h06: return 1;
      7'h5B: return 2;
      7'h4F: return 3;
      7'h66: return 4;
      7'h6D: return 5;
      7'h7D: return 6;
      7'h07: return 7;
      default: return -1;
    endcase
  endfunction

  // Waits out the blank gap and returns the displayed hole. Sometimes it
  // presses buttons during the gap, and those presses must be ignored.
  task automatic wait_mole(output int d);
    int n;
    int exp_gap;
    bit poked;
    n = 0;
    poked = 0;
    exp_gap = GAP_CYCLES - since_end;
    while (seg == 7'h00 && n < 200) begin
      if (n == 1 && exp_gap >= 15 && $urandom_range(0, 1) == 1) begin
        btn = 8'($urandom_range(1, 255));
        poked = 1;
      end
      if (n == 4 && poked) btn = 8'd0;
      tick();
      n++;
    end
    btn = 8'd0;
    check_val("gap_length", n, exp_gap);
    check_val("gap_score_hold", led_score, exp_score);
    check_val("mole_dp_low", dp, 0);
    d = seg2digit(seg);
    check_val("digit_valid", (d >= 0), 1);
    check_val("digit_no_repeat", (d != prev_digit), 1);
    if (d < 0) d = 0;
    prev_digit = d;
  endtask

  // Plays one mole with the given action and checks the outcome.
  task automatic play_mole(input int action, input bit last);
    int d;
    int n;
    int end_t;
    logic [7:0] mask;
    logic [6:0] code;
    wait_mole(d);
    code = seg;
    if (action == ACT_IDLE) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (seg == code && n < 300);
      check_val("timeout_length", n, MOLE_CYCLES);
      since_end = 0;
    end else begin
      case (action)
        ACT_HIT:   mask = 8'd1 << d;
        ACT_HIT_X: mask = (8'd1 << d) | 8'($urandom_range(1, 255));
        default:   mask = (8'd1 << ((d + 1) % 8)) | (8'($urandom_range(0, 255)) & ~(8'd1 << d));
      endcase
      btn = mask;
      end_t = 0;
      for (int i = 1; i <= 5; i++) begin
        tick();
        if (end_t == 0 && seg != code) end_t = i;
      end
      btn = 8'd0;
      check_val("press_latency_ok", (end_t >= 3 && end_t <= 4), 1);
      if (action != ACT_WRONG && exp_score < 255) exp_score++;
      since_end = (end_t == 0) ? 0 : 5 - end_t;
    end
    exp_q.push_back(8'(exp_score));
    check_val("score_after_mole", led_score, exp_q.pop_front());
    if (last) begin
      check_val("over_seg", seg, 7'h40);
      check_val("over_dp", dp, 1);
    end else begin
      check_val("end_seg_blank", seg, 0);
      check_val("end_dp", dp, 0);
    end
  endtask

  task automatic play_game();
    int n;
    for (int m = 0; m < NUM_MOLES; m++) play_mole(plan[m], (m == NUM_MOLES - 1));
    n = $urandom_range(3, 10);
    repeat (n) tick();
    check_val("over_hold_seg", seg, 7'h40);
    check_val("over_hold_dp", dp, 1);
    check_val("over_hold_score", led_score, exp_score);
  endtask

  // Any press in GAME_OVER clears the score and restarts with a gap.
  task automatic restart();
    int t;
    t = 0;
    btn = 8'($urandom_range(1, 255));
    while (dp == 1'b1 && t < 10) begin
      tick();
      t++;
    end
    btn = 8'd0;
    check_val("restart_latency_ok", (t >= 3 && t <= 4), 1);
    check_val("restart_score", led_score, 0);
    check_val("restart_seg", seg, 0);
    exp_score = 0;
    since_end = 0;
  endtask

  task automatic set_plan(input int a0, input int a1, input int a2, input int a3);
    plan[0] = a0;
    plan[1] = a1;
    plan[2] = a2;
    plan[3] = a3;
  endtask

  initial begin
    int d;
    exp_score = 0;
    prev_digit = 0;
    since_end = 0;

    // Reset.
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_val("reset_seg", seg, 0);
    check_val("reset_dp", dp, 0);
    check_val("reset_score", led_score, 0);
    rst_n = 1'b1;

    // Game with all hits.
    set_plan(ACT_HIT, ACT_HIT_X, ACT_HIT, ACT_HIT_X);
    play_game();
    check_val("all_hit_score", led_score, 4);
    restart();

    // Game with no presses.
    set_plan(ACT_IDLE, ACT_IDLE, ACT_IDLE, ACT_IDLE);
    play_game();
    check_val("idle_score", led_score, 0);
    restart();

    // Game with one wrong press and three hits.
    set_plan(ACT_WRONG, ACT_HIT_X, ACT_HIT, ACT_HIT);
    play_game();
    check_val("three_hit_score", led_score, 3);
    restart();

    // Two hits, then reset during the third mole.
    play_mole(ACT_HIT, 0);
    play_mole(ACT_HIT, 0);
    check_val("pre_reset_score", led_score, 2);
    wait_mole(d);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("midreset_seg", seg, 0);
    check_val("midreset_dp", dp, 0);
    check_val("midreset_score", led_score, 0);
    tick();
    rst_n = 1'b1;
    exp_score = 0;
    prev_digit = 0;
    since_end = 0;

    // Randomised games after the reset.
    for (int g = 0; g < 3; g++) begin
      for (int m = 0; m < NUM_MOLES; m++) plan[m] = $urandom_range(0, 3);
      play_game();
      restart();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/whack_a_mole.md
Name: whack_a_mole

Overview:
Single-player whack-a-mole game on 8 buttons and a 7-segment display. A pseudo-random "mole" hole (0-7) is shown as a digit on the display. The player must press the matching button before a timeout. Hits are counted on an 8-bit LED bar. This is the top-level game core, with buttons fed directly from the board inputs.

Parameters:
MOLE_CYCLES, 200000, clock cycles a mole stays up (timeout)
GAP_CYCLES, 50000, blank cycles between moles
NUM_MOLES, 20, moles per game before game over
LFSR_SEED, 8'hA5, LFSR value loaded at reset (must be nonzero)

Ports:
clk  in  1  system clock, 1 MHz nominal; all logic on the rising edge
rst_n  in  1  reset; asynchronous, active-low
btn  in  8  raw asynchronous buttons, active-high; btn[i] whacks hole i
seg  out  7  7-segment drive, active-high; seg[0]=a … seg[6]=g
dp  out  1  decimal point; high during GAME_OVER
led_score  out  8  current hit count, binary

Behaviour:
- Reset (async assert): seg=0, dp=0, led_score=0, state=GAP, counters=0, mole_count=0, lfsr=LFSR_SEED, prev_pos=0. All outputs are registered.
- Input path: btn passes through a 2-FF synchronizer, then rising-edge detect, giving edge[7:0] (1-cycle pulses). Press-to-edge latency is 3 clocks. No debounce is needed; the bench drives clean levels.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It shifts every clock in every state.
- State GAP:
  - seg=0 (blank), for exactly GAP_CYCLES cycles.
  - Then it picks pos=lfsr[2:0]. If pos==prev_pos, pos=(pos+1) mod 8.
  - It stores pos in prev_pos and enters MOLE.
  - Button edges are ignored.
- State MOLE:
  - seg shows the digit pos from the first MOLE cycle, using the codes 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - Hit: edge[pos]==1, regardless of other bits set that cycle. led_score increments on the next clock, saturating at 255. The mole ends.
  - Miss: any edge with edge[pos]==0, or the timer reaching MOLE_CYCLES cycles. The mole ends with no score change.
  - Hit and timeout on the same cycle counts as a hit.
  - Mole end: mole_count+1. If mole_count reaches NUM_MOLES, go to GAME_OVER; otherwise go to GAP with the timer cleared.
- State GAME_OVER:
  - seg=7'h40 (dash), dp=1, led_score holds.
  - Any edge restarts the game: led_score=0, mole_count=0, dp=0, state=GAP.
  - The LFSR is not reseeded, so mole sequences differ between games.
- Counters: timer wide enough for max(MOLE_CYCLES, GAP_CYCLES) (18 bits at defaults). mole_count is 8 bits.
- Reset asserted mid-game returns everything to reset values immediately.
- Sequence determinism: for a given seed and reset instant, the mole position sequence is fixed. The bench reads the current mole from seg rather than predicting it.

Test Plan:
1. Reset with MOLE_CYCLES=100, GAP_CYCLES=20, NUM_MOLES=4 → seg=0, dp=0, led_score=0. After 20 clocks of blank, seg shows one of 3F/06/5B/4F/66/6D/7D/07.
2. Decode the seg digit d and pulse btn[d] high for 5 clocks → led_score=1 within 4 clocks of the press, then seg blanks. Repeat for all 4 moles → led_score=4, then seg=40, dp=1.
3. Press no buttons → each mole lasts exactly 100 cycles. After 4 moles: seg=40, dp=1, led_score=0.
4. While mole d is shown, press btn[(d+1) mod 8] → mole ends (seg=0), led_score unchanged. Pressing btn[d] together with another button → counts as a hit.
5. In GAME_OVER with led_score=3, press any button → led_score=0, dp=0, a new game starts with the GAP phase.
6. Assert rst_n=0 mid-MOLE with led_score=2 → seg=0, dp=0, led_score=0 immediately; after release, normal play resumes. Consecutive mole positions never repeat.
